// File: rtl/seg7_debug_display.sv
// seg7_debug_display: shows a 10-bit value in decimal on a 4-digit multiplexed common-anode display
module seg7_debug_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  value_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        busy_o,
    output logic [15:0] bcd_o
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [9:0]     last_val;
    logic [25:0]    sreg;
    logic [25:0]    adj;
    logic [3:0]     cnt;
    logic [CW-1:0]  scan_cnt;
    logic [1:0]     idx;
    logic [1:0]     nidx;
    logic [3:0]     digit;
    logic           blank;
    logic           tick;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign dp_o = 1'b1;

    // double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        adj = sreg;
        for (int i = 0; i < 4; i++)
            adj[10+4*i +: 4] = (sreg[10+4*i +: 4] >= 4'd5) ? sreg[10+4*i +: 4] + 4'd3 : sreg[10+4*i +: 4];
    end

    // converter: start on a changed value, ten correct-and-shift steps, then publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_val <= '0;
            sreg     <= '0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            bcd_o    <= '0;
        end else begin
            case (state)
                IDLE: if (value_i != last_val) begin
                    sreg     <= {16'h0000, value_i};
                    last_val <= value_i;
                    cnt      <= '0;
                    busy_o   <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    sreg <= {adj[24:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= DONE;
                end
                DONE: begin
                    bcd_o  <= sreg[25:10];
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // next digit to be shown and whether it is a leading zero
    always_comb begin
        nidx  = idx + 2'd1;
        digit = bcd_o[4*nidx +: 4];
        tick  = scan_cnt == CW'(SCAN_DIV - 1);
        blank = BLANK_LZ && ((nidx == 2'd3 && ~|bcd_o[15:12]) ||
                             (nidx == 2'd2 && ~|bcd_o[15:8]) ||
                             (nidx == 2'd1 && ~|bcd_o[15:4]));
    end

    // scan divider: on each wrap register the enable and segments of the next digit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an_o     <= 4'hF;
            seg_o    <= 7'h7F;
        end else if (tick) begin
            scan_cnt <= '0;
            idx      <= nidx;
            an_o     <= ~(4'b0001 << nidx);
            seg_o    <= blank ? 7'h7F : decode(digit);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_debug_display.sv
// tb_seg7_debug_display: randomized and directed checks against a decimal reference model
module tb_seg7_debug_display;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  value = '0;
    logic [3:0]  an, an0;
    logic [6:0]  seg, seg0;
    logic        dp, dp0, busy, busy0;
    logic [15:0] bcd, bcd0;
    int          tests = 0;
    int          fails = 0;
    int          edges = 0;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg7_debug_display #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value_i(value), .an_o(an), .seg_o(seg),
        .dp_o(dp), .busy_o(busy), .bcd_o(bcd));

    seg7_debug_display #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .value_i(value), .an_o(an0), .seg_o(seg0),
        .dp_o(dp0), .busy_o(busy0), .bcd_o(bcd0));

    always #5 clk = ~clk;

    // rising edges since the last reset release
    always @(posedge clk or negedge rst) edges <= rst ? edges + 1 : 0;

    function automatic logic [15:0] exp_bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i, input bit blank_lz);
        int p;
        p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
        if (blank_lz && i > 0 && v < p) return 7'h7F;
        return SEG[(v / p) % 10];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        repeat (3) step();
        tests++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: an=%b seg=%b dp=%b busy=%b bcd=%h, required 1111 1111111 1 0 0000",
                     an, seg, dp, busy, bcd);
        end
        rst = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            tests++;
            if (busy !== 1'b0 || (c < DIV && an !== 4'hF) || (c == DIV && (an !== 4'b1101 || seg !== 7'h7F))) begin
                fails++;
                $display("FAIL reset_release c=%0d: busy=%b an=%b seg=%b", c, busy, an, seg);
            end
        end
    endtask

    task automatic test_latency();
        int n;
        value = 10'd1023;
        step();
        wait_done(n);
        tests++;
        if (n !== 11 || bcd !== 16'h1023) begin
            fails++;
            $display("FAIL latency: busy cycles=%0d bcd=%h, required 11 1023", n, bcd);
        end
    endtask

    task automatic test_scan(input int v);
        int n, i;
        value = 10'(v);
        step();
        wait_done(n);
        repeat (20) step();
        tests++;
        if (n >= 100 || bcd !== exp_bcd(v) || bcd0 !== exp_bcd(v)) begin
            fails++;
            $display("FAIL scan_bcd v=%0d: bcd=%h bcd0=%h, required %h", v, bcd, bcd0, exp_bcd(v));
        end
        for (int c = 0; c < 16; c++) begin
            i = (edges / DIV) % 4;
            tests++;
            if (an !== ~(4'b0001 << i) || an0 !== an || seg !== exp_seg(v, i, 1'b1) ||
                seg0 !== exp_seg(v, i, 1'b0) || dp !== 1'b1) begin
                fails++;
                $display("FAIL scan v=%0d digit=%0d: an=%b an0=%b seg=%b seg0=%b, required an=%b seg=%b seg0=%b",
                         v, i, an, an0, seg, seg0, ~(4'b0001 << i), exp_seg(v, i, 1'b1), exp_seg(v, i, 1'b0));
            end
            step();
        end
    endtask

    task automatic test_skip();
        int n;
        value = 10'd500;
        step();
        step();
        step();
        value = 10'd42;
        wait_done(n);
        tests++;
        if (n !== 9 || bcd !== 16'h0500) begin
            fails++;
            $display("FAIL skip_first: cycles=%0d bcd=%h, required 9 0500", n, bcd);
        end
        step();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL skip_gap: busy=%b, required 1 after one idle cycle", busy);
        end
        wait_done(n);
        tests++;
        if (n >= 100 || bcd !== 16'h0042) begin
            fails++;
            $display("FAIL skip_second: bcd=%h, required 0042", bcd);
        end
    endtask

    task automatic test_sweep();
        int n;
        for (int v = 0; v < 1024; v++) begin
            value = 10'(v);
            step();
            wait_done(n);
            tests++;
            if (n >= 100 || bcd !== exp_bcd(v)) begin
                fails++;
                $display("FAIL sweep v=%0d: bcd=%h, required %h", v, bcd, exp_bcd(v));
            end
        end
    endtask

    task automatic test_midreset();
        int n;
        value = 10'd999;
        repeat (4) step();
        #2 rst = 1'b0;
        #1;
        tests++;
        if (bcd !== 16'h0000 || busy !== 1'b0 || an !== 4'hF || seg !== 7'h7F) begin
            fails++;
            $display("FAIL midreset: bcd=%h busy=%b an=%b seg=%b, required 0000 0 1111 1111111", bcd, busy, an, seg);
        end
        step();
        rst = 1'b1;
        step();
        wait_done(n);
        tests++;
        if (n >= 100 || bcd !== 16'h0999) begin
            fails++;
            $display("FAIL midreset_restart: bcd=%h, required 0999", bcd);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan(7);
        test_skip();
        for (int k = 0; k < 8; k++) test_scan(int'($urandom_range(0, 1023)));
        test_scan(1000);
        test_scan(0);
        test_sweep();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
